// File: rtl/imem_loader.sv
// imem_loader: streams instruction words into the processor's instruction
// memory from address 0, verifies a trailing 32-bit additive checksum and
// releases the core from reset only after a successful load.
// Optional build macro: IMEM_LOADER_TIMEOUT_EN adds an input-idle watchdog
// that aborts a stalled load after TIMEOUT cycles without a transfer.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_50,
  input  logic              arstn,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rstn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Reject parameter sets the address space or watchdog cannot support.
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || TIMEOUT < 1) begin : g_param_check
    $error("imem_loader: DEPTH must be 1..2**ADDR_W and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_CHECK   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state, w_state_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [31:0]         r_mem_wdata, w_mem_wdata_nxt;
  logic                r_core_rstn, w_core_rstn_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]   r_last, w_last_nxt;
  logic [31:0]         r_acc, w_acc_nxt;

  logic                w_ready;
  logic                w_xfer;
  logic                w_count_ok;
  logic [ADDR_W-1:0]   w_last_idx;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int                LP_TW    = $clog2(TIMEOUT + 1);
  localparam logic [LP_TW-1:0]  LP_TO_M1 = LP_TW'(TIMEOUT - 1);
  logic [LP_TW-1:0]    r_idle_cnt, w_idle_nxt;
`else
  // Without the watchdog the loader waits for input indefinitely.
`endif

  // The loader accepts words only while a load is in progress.
  assign w_ready    = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_xfer     = in_valid && w_ready;
  assign w_count_ok = (word_count != '0) && (word_count <= LP_DEPTH);
  // Count of DEPTH == 2**ADDR_W wraps its low bits to 0; minus one still gives DEPTH-1.
  assign w_last_idx = word_count[ADDR_W-1:0] - ADDR_W'(1);

  assign in_ready  = w_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign core_rstn = r_core_rstn;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

  // State register.
  always_ff @(posedge clk_50 or negedge arstn) begin
    if (!arstn) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and next-register decode for every loader phase.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_core_rstn_nxt = r_core_rstn;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_err_nxt       = r_err;
    w_idx_nxt       = r_idx;
    w_last_nxt      = r_last;
    w_acc_nxt       = r_acc;
`ifdef IMEM_LOADER_TIMEOUT_EN
    w_idle_nxt      = r_idle_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_count_ok) begin
            // Bad request: flag it but leave a running core alone.
            w_err_nxt  = 1'b1;
            w_done_nxt = 1'b0;
          end else begin
            w_last_nxt      = w_last_idx;
            w_idx_nxt       = '0;
            w_acc_nxt       = '0;
            w_busy_nxt      = 1'b1;
            w_done_nxt      = 1'b0;
            w_err_nxt       = 1'b0;
            w_core_rstn_nxt = 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
            w_idle_nxt      = '0;
`endif
            w_state_nxt     = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (w_xfer) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_idx;
          w_mem_wdata_nxt = in_data;
          w_acc_nxt       = r_acc + in_data;
          w_idx_nxt       = r_idx + ADDR_W'(1);
          if (r_idx == r_last) w_state_nxt = S_CHECK;
        end
      end

      S_CHECK: begin
        if (w_xfer) begin
          // The checksum word is compared only, never written.
          if (in_data == r_acc) begin
            w_state_nxt = S_RELEASE;
          end else begin
            w_err_nxt       = 1'b1;
            w_busy_nxt      = 1'b0;
            w_core_rstn_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
          end
        end
      end

      S_RELEASE: begin
        w_done_nxt      = 1'b1;
        w_busy_nxt      = 1'b0;
        w_core_rstn_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
    // Watchdog: any transfer restarts the idle count; hitting the limit aborts.
    if (w_ready) begin
      if (w_xfer) begin
        w_idle_nxt = '0;
      end else if (r_idle_cnt == LP_TO_M1) begin
        w_idle_nxt      = '0;
        w_err_nxt       = 1'b1;
        w_busy_nxt      = 1'b0;
        w_core_rstn_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end else begin
        w_idle_nxt = r_idle_cnt + LP_TW'(1);
      end
    end
`endif
  end

  // Output, address and checksum registers; reset aborts any load in flight.
  always_ff @(posedge clk_50 or negedge arstn) begin
    if (!arstn) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_rstn <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_last      <= '0;
      r_acc       <= '0;
`ifdef IMEM_LOADER_TIMEOUT_EN
      r_idle_cnt  <= '0;
`endif
    end else begin
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_core_rstn <= w_core_rstn_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_idx       <= w_idx_nxt;
      r_last      <= w_last_nxt;
      r_acc       <= w_acc_nxt;
`ifdef IMEM_LOADER_TIMEOUT_EN
      r_idle_cnt  <= w_idle_nxt;
`endif
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader for the pipeline_processor instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-memory addresses starting at 0. It then checks a trailing checksum word and releases the processor from reset only if the checksum matches. It sits between the host/boot source and the processor's instruction memory write port.

Parameters:
ADDR_W, 8, instruction memory address width
DEPTH, 256, number of instruction words, must not exceed 2**ADDR_W
TIMEOUT, 1024, idle-cycle limit for the watchdog; used only when IMEM_LOADER_TIMEOUT_EN is defined

Ports:
clk_50  in  1  system clock, all logic on its rising edge
arstn  in  1  asynchronous active-low reset
start  in  1  request to begin a load; sampled in IDLE only
word_count  in  ADDR_W+1  number of payload words; sampled together with start
in_valid  in  1  input word valid
in_data  in  32  input word
in_ready  out  1  loader can accept a word this cycle
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  instruction memory write address
mem_wdata  out  32  instruction memory write data
core_rstn  out  1  active-low reset to the processor core
busy  out  1  load in progress
done  out  1  last load succeeded; level signal
err  out  1  last load or start request failed; level signal

Behaviour:
- Reset (arstn=0, asynchronous):
  - State goes to IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rstn=0, busy=0, done=0, err=0.
  - Internal index and checksum accumulator are cleared.
  - After arstn rises, core_rstn stays 0 until a load succeeds.
- States: IDLE, LOAD, CHECK, RELEASE.
- Transfer rule: a word transfers only on a cycle where in_valid=1 and in_ready=1. in_data is ignored whenever in_ready=0.
- IDLE:
  - in_ready=0.
  - On start=1, if word_count==0 or word_count>DEPTH: err=1, done=0, stay in IDLE. core_rstn is unchanged.
  - On start=1 with a valid word_count:
    - latch the count, clear the index and the accumulator;
    - busy=1, done=0, err=0, core_rstn=0 (a reload re-holds a running core);
    - next state LOAD.
- LOAD:
  - in_ready=1.
  - Each transfer produces, one cycle later, a single-cycle write: mem_we=1, mem_addr=index, mem_wdata=word.
  - On each transfer: accumulator += word, modulo 2**32; index increments.
  - The transfer of word number count-1 moves the state to CHECK.
  - mem_we is 0 on every cycle that is not a registered write.
- CHECK:
  - in_ready=1.
  - The next transfer is the checksum word. It is never written to memory.
  - Checksum equal to the accumulator: next state RELEASE.
  - Mismatch: err=1, busy=0, core_rstn=0, next state IDLE.
- RELEASE: lasts one cycle. Sets done=1, busy=0, core_rstn=1, in_ready=0, then returns to IDLE.
- done and err hold their values until the next accepted start or until reset.
- start is ignored in LOAD, CHECK and RELEASE.
- mem_addr and mem_wdata hold their last written values between writes.
- Latency: the last payload write appears the cycle after its transfer. core_rstn rises 2 cycles after the checksum transfer (CHECK evaluates, then RELEASE registers).
- Back-to-back transfers, one per cycle, are supported at full rate.
- arstn asserted mid-load aborts immediately. Words already written stay in memory; the core stays in reset.

Optional Feature:
IMEM_LOADER_TIMEOUT_EN:
- Defined: an idle counter runs in LOAD and CHECK. It clears on every transfer and increments on every other cycle.
- When it reaches TIMEOUT: err=1, busy=0, core_rstn=0, state goes to IDLE.
- Not defined: no counter; the loader waits for input indefinitely.

Test Plan:
1. Reset, then start with word_count=3, words 0x00000013, 0x00100093, 0x00208113, checksum 0x003081B9 -> writes to addresses 0, 1, 2 with those data; no write for the checksum; done=1; core_rstn=1 two cycles after the checksum transfer.
2. Same load with checksum 0x00000000 -> err=1, done=0, core_rstn stays 0, busy falls, state back to IDLE.
3. start with word_count=0, then with word_count=DEPTH+1 -> err=1 both times, in_ready stays 0, no mem_we.
4. After a successful load, start with word_count=1, word 0xDEADBEEF, checksum 0xDEADBEEF -> core_rstn drops the cycle after start and returns to 1 after the load; a single write of 0xDEADBEEF to address 0.
5. Drop arstn after 2 of 4 words, then raise it -> all outputs at reset values, core_rstn=0, and a new 4-word load completes correctly.
6. With IMEM_LOADER_TIMEOUT_EN and TIMEOUT=16: start, send 1 word, then hold in_valid=0 -> err=1 exactly 16 cycles after the last transfer; core_rstn stays 0.
